// File: rtl/gpu_cmd_sequencer.sv
// Snapshots gamecentre outputs once per frame and emits an ordered draw-command list over valid/ready.
// Optional GPU_SCORE_EN adds a 16-bit score register and a SCORE command ahead of END.
module gpu_cmd_sequencer #(
  parameter int SCREEN_W = 240,
  parameter int GROUND_Y = 100,
  parameter int DINO_X   = 16,
  parameter int DINO_W   = 16,
  parameter int DINO_H   = 16,
  parameter int OBS_W    = 16,
  parameter int OBS_H    = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       gpu_en,
  input  logic [6:0] dino_y,
  input  logic [8:0] obstacle_x,
  input  logic [1:0] state,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_op,
  output logic [8:0] cmd_x,
  output logic [7:0] cmd_y,
  output logic [8:0] cmd_w,
  output logic [5:0] cmd_h,
  output logic       frame_busy,
  output logic [7:0] drop_cnt
);

  localparam logic [2:0] OP_CLEAR  = 3'd0;
  localparam logic [2:0] OP_GROUND = 3'd1;
  localparam logic [2:0] OP_DINO   = 3'd2;
  localparam logic [2:0] OP_OBST   = 3'd3;
  localparam logic [2:0] OP_PROMPT = 3'd4;
`ifdef GPU_SCORE_EN
  localparam logic [2:0] OP_SCORE  = 3'd5;
`endif
  localparam logic [2:0] OP_END    = 3'd7;

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, WAIT_ACK = 2'd2} fsm_t;
  fsm_t st_q, st_d;

  logic [6:0] snap_y;
  logic [8:0] snap_x;
  logic [1:0] snap_st;
  logic [2:0] op_q, idx_q, nxt_op, fld_op, after_prompt;
  logic [8:0] x_q, f_x, w_q, f_w;
  logic [7:0] y_q, f_y;
  logic [5:0] h_q, f_h;
  logic [9:0] obs_rem;
  logic       obs_vis, start, xfer;
`ifdef GPU_SCORE_EN
  logic [15:0] score_q;
`endif

  assign start   = (st_q == IDLE) && frame_tick && gpu_en;
  assign xfer    = (st_q == WAIT_ACK) && cmd_ready;
  assign obs_rem = 10'(SCREEN_W) - {1'b0, snap_x};
  assign obs_vis = {1'b0, snap_x} < 10'(SCREEN_W);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) st_q <= IDLE;
    else      st_q <= st_d;
  end

  always_comb begin
    st_d = st_q;
    case (st_q)
      IDLE:     if (start) st_d = WAIT_ACK;
      EMIT:     st_d = WAIT_ACK;
      WAIT_ACK: if (cmd_ready) st_d = (op_q == OP_END) ? IDLE : EMIT;
      default:  st_d = IDLE;
    endcase
  end

`ifdef GPU_SCORE_EN
  assign after_prompt = OP_SCORE;
`else
  assign after_prompt = OP_END;
`endif

  // Skip logic: pick the next command from the one just transferred and the snapshot.
  always_comb begin
    nxt_op = OP_END;
    case (op_q)
      OP_CLEAR:  nxt_op = OP_GROUND;
      OP_GROUND: nxt_op = OP_DINO;
      OP_DINO:   nxt_op = obs_vis ? OP_OBST : ((snap_st == 2'd0) ? OP_PROMPT : after_prompt);
      OP_OBST:   nxt_op = (snap_st == 2'd0) ? OP_PROMPT : after_prompt;
      OP_PROMPT: nxt_op = after_prompt;
      default:   nxt_op = OP_END;
    endcase
  end

  // CLEAR needs no snapshot data, so it can be built in the same cycle the snapshot is taken.
  assign fld_op = start ? OP_CLEAR : idx_q;

  always_comb begin
    f_x = '0;
    f_y = '0;
    f_w = '0;
    f_h = '0;
    case (fld_op)
      OP_CLEAR:  f_w = 9'(SCREEN_W);
      OP_GROUND: begin
        f_y = 8'(GROUND_Y);
        f_w = 9'(SCREEN_W);
        f_h = 6'd1;
      end
      OP_DINO: begin
        f_x = 9'(DINO_X);
        f_y = 8'(10'(GROUND_Y) - 10'(DINO_H) - {3'b0, snap_y});
        f_w = 9'(DINO_W);
        f_h = 6'(DINO_H);
      end
      OP_OBST: begin
        f_x = snap_x;
        f_y = 8'(10'(GROUND_Y) - 10'(OBS_H));
        f_w = (obs_rem < 10'(OBS_W)) ? 9'(obs_rem) : 9'(OBS_W);
        f_h = 6'(OBS_H);
      end
      OP_PROMPT: begin
        f_x = 9'(SCREEN_W / 2);
        f_y = 8'(GROUND_Y / 2);
      end
`ifdef GPU_SCORE_EN
      OP_SCORE: begin
        f_x = score_q[8:0];
        f_w = {1'b0, score_q[15:8]};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      snap_y  <= '0;
      snap_x  <= '0;
      snap_st <= '0;
      op_q    <= OP_CLEAR;
      idx_q   <= OP_CLEAR;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
    end else begin
      if (start) begin
        snap_y  <= dino_y;
        snap_x  <= obstacle_x;
        snap_st <= state;
      end
      if (start || st_q == EMIT) begin
        op_q <= fld_op;
        x_q  <= f_x;
        y_q  <= f_y;
        w_q  <= f_w;
        h_q  <= f_h;
      end
      if (xfer) idx_q <= nxt_op;
    end
  end

`ifdef GPU_SCORE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) score_q <= '0;
    else if (start) begin
      if (state == 2'd0)                        score_q <= '0;
      else if (state == 2'd1 || state == 2'd2) score_q <= score_q + 16'd1;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) drop_cnt <= '0;
    else if (frame_tick && st_q != IDLE && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
  end

  always_comb begin
    cmd_valid  = (st_q == WAIT_ACK);
    frame_busy = (st_q != IDLE);
    cmd_op     = cmd_valid ? op_q : 3'd0;
    cmd_x      = cmd_valid ? x_q  : 9'd0;
    cmd_y      = cmd_valid ? y_q  : 8'd0;
    cmd_w      = cmd_valid ? w_q  : 9'd0;
    cmd_h      = cmd_valid ? h_q  : 6'd0;
  end

endmodule

// File: tb/tb_gpu_cmd_sequencer.sv
// Directed self-checking bench for gpu_cmd_sequencer; expected command lists are hand-derived.
module tb_gpu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst, frame_tick, gpu_en, cmd_ready;
  logic [6:0] dino_y;
  logic [8:0] obstacle_x;
  logic [1:0] state;
  logic       cmd_valid, frame_busy;
  logic [2:0] cmd_op;
  logic [8:0] cmd_x, cmd_w;
  logic [7:0] cmd_y, drop_cnt;
  logic [5:0] cmd_h;

  gpu_cmd_sequencer dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick), .gpu_en(gpu_en),
    .dino_y(dino_y), .obstacle_x(obstacle_x), .state(state),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
    .frame_busy(frame_busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

`ifdef GPU_SCORE_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int q_op[$], q_x[$], q_y[$], q_w[$], q_h[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Each op is encoded as op+1 per nibble so a missing CLEAR still changes the value.
  function automatic logic [31:0] seq();
    logic [31:0] s = 0;
    foreach (q_op[i]) s = (s << 4) | 32'(q_op[i] + 1);
    return s;
  endfunction

  task automatic clear_q();
    q_op.delete(); q_x.delete(); q_y.delete(); q_w.delete(); q_h.delete();
  endtask

  // Records transfers from the current negedge until END, then lets END complete.
  task automatic collect();
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      if (cmd_valid && cmd_ready) begin
        q_op.push_back(int'(cmd_op)); q_x.push_back(int'(cmd_x)); q_y.push_back(int'(cmd_y));
        q_w.push_back(int'(cmd_w));   q_h.push_back(int'(cmd_h));
        if (cmd_op == 3'd7) done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    if (!done) chk("frame_timeout", 0, 1);
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [6:0] dy, input logic [8:0] ox, input logic [1:0] st);
    dino_y = dy; obstacle_x = ox; state = st; gpu_en = 1'b1; cmd_ready = 1'b1; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    clear_q();
    collect();
  endtask

  initial begin
    bit found, saw;
    rst = 1'b0; frame_tick = 1'b0; gpu_en = 1'b0; cmd_ready = 1'b0;
    dino_y = '0; obstacle_x = '0; state = '0;
    repeat (2) @(negedge clk);
    chk("reset_valid", cmd_valid, 0);
    chk("reset_busy", frame_busy, 0);
    chk("reset_drop", drop_cnt, 0);
    chk("reset_op", cmd_op, 0);
    rst = 1'b1;
    @(negedge clk);

    // Basic frame, obstacle fully on screen
    run_frame(7'd0, 9'd100, 2'd1);
    chk("t2_seq", seq(), SC ? 32'h123468 : 32'h12348);
    chk("t2_clear_w", q_w[0], 240);
    chk("t2_ground_y", q_y[1], 100);
    chk("t2_ground_h", q_h[1], 1);
    chk("t2_dino_y", q_y[2], 84);
    chk("t2_dino_x", q_x[2], 16);
    chk("t2_obst_x", q_x[3], 100);
    chk("t2_obst_y", q_y[3], 74);
    chk("t2_obst_w", q_w[3], 16);
    chk("t2_obst_h", q_h[3], 26);
    chk("t2_idle_busy", frame_busy, 0);

    // Top of jump, obstacle clipped, then culled
    run_frame(7'd36, 9'd232, 2'd2);
    chk("t3_dino_y", q_y[2], 48);
    chk("t3_obst_w", q_w[3], 8);
    run_frame(7'd0, 9'd240, 2'd1);
    chk("t3_cull_seq", seq(), SC ? 32'h12368 : 32'h1238);

    // Init state prompt, then a disabled tick
    run_frame(7'd0, 9'd100, 2'd0);
    chk("t4_seq", seq(), SC ? 32'h1234568 : 32'h123458);
    chk("t4_prompt_x", q_x[4], 120);
    chk("t4_prompt_y", q_y[4], 50);
    gpu_en = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    saw = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cmd_valid || frame_busy) saw = 1'b1;
      @(negedge clk);
    end
    chk("t4_noen_activity", saw, 0);
    chk("t4_noen_drop", drop_cnt, 0);

    // Stall on DINO with input churn and ticks
    dino_y = 7'd10; obstacle_x = 9'd100; state = 2'd1; gpu_en = 1'b1; cmd_ready = 1'b1; frame_tick = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      frame_tick = 1'b0;
      if (cmd_valid && cmd_op == 3'd2) begin
        cmd_ready = 1'b0;
        found = 1'b1;
      end
    end
    chk("t5_dino_found", found, 1);
    for (int i = 0; i < 5; i++) begin
      frame_tick = (i % 2 == 0);
      dino_y = 7'(i * 7 + 3);
      @(negedge clk);
      chk("t5_hold_valid", cmd_valid, 1);
      chk("t5_hold_op", cmd_op, 2);
      chk("t5_hold_y", cmd_y, 74);
      chk("t5_hold_x", cmd_x, 16);
    end
    frame_tick = 1'b0;
    chk("t5_busy", frame_busy, 1);
    cmd_ready = 1'b1;
    clear_q();
    collect();
    chk("t5_rest_seq", seq(), SC ? 32'h3468 : 32'h348);
    chk("t5_drop", drop_cnt, 3);

    // Reset mid-frame
    state = 2'd1; gpu_en = 1'b1; cmd_ready = 1'b0; frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    chk("t1_pre_valid", cmd_valid, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("t1_rst_valid", cmd_valid, 0);
    chk("t1_rst_busy", frame_busy, 0);
    chk("t1_rst_drop", drop_cnt, 0);
    chk("t1_rst_w", cmd_w, 0);
    rst = 1'b1;
    @(negedge clk);
    run_frame(7'd0, 9'd100, 2'd1);
    chk("t1_restart_first", q_op[0], 0);
    chk("t1_restart_seq", seq(), SC ? 32'h123468 : 32'h12348);

`ifdef GPU_SCORE_EN
    run_frame(7'd0, 9'd100, 2'd0);
    chk("t6_score_clear0", q_x[q_x.size()-2], 0);
    for (int f = 1; f <= 4; f++) begin
      run_frame(7'd0, 9'd100, 2'd2);
      chk("t6_score_x", q_x[q_x.size()-2], 32'(f));
      chk("t6_score_w", q_w[q_w.size()-2], 0);
    end
    run_frame(7'd0, 9'd100, 2'd0);
    chk("t6_score_reset", q_x[q_x.size()-2], 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
